// File: rtl/apb_btn_led_pkg.sv
// Shared constants and types for the APB button/LED target.
// Register offsets are keyed on PADDR[4:2].
package apb_btn_led_pkg;

    localparam logic [2:0] OFF_BTN_STATE = 3'd0;
    localparam logic [2:0] OFF_EDGE      = 3'd1;
    localparam logic [2:0] OFF_IRQ_EN    = 3'd2;
    localparam logic [2:0] OFF_LED       = 3'd3;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_ACK
    } apb_state_e;

endpackage

// File: rtl/apb_btn_led_target_if.sv
// APB3 signal bundle between the ESS initiator slot and the button/LED target.
interface apb_btn_led_target_if;

    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, stability counter and debounced level.
// rise pulses in the cycle whose edge moves the level from 0 to 1.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign level = level_q;
    assign rise  = sync_q[1] & ~level_q & (cnt_q == CNT_MAX);

endmodule

// File: rtl/apb_btn_led_target.sv
// APB3 target with debounced buttons (W1C rising-edge status + level IRQ) and LED register.
// Every transfer takes one wait state; unmapped offsets answer with PSLVERR.
module apb_btn_led_target
    import apb_btn_led_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned NUM_LED         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_btn_led_target_if.slave  apb,
    input  logic [NUM_BTN-1:0]   BTN_IN,
    output logic [NUM_LED-1:0]   LED_OUT,
    output logic                 IRQ
);

    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_rise;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .PCLK    (PCLK),
            .PRESET  (PRESET),
            .btn_raw (BTN_IN[i]),
            .level   (btn_level[i]),
            .rise    (btn_rise[i])
        );
    end

    apb_state_e         state_q;
    logic               pready_q;
    logic               pslverr_q;
    logic [31:0]        prdata_q;
    logic [NUM_BTN-1:0] edge_q, edge_d;
    logic [NUM_BTN-1:0] irq_en_q, irq_en_d;
    logic [NUM_LED-1:0] led_q, led_d;
    logic               irq_q;

    logic [2:0]  off;
    logic [31:0] rdata;
    logic        rerr;
    logic        wr_en;
    logic        unused_bus;

    assign off        = apb.PADDR[4:2];
    assign unused_bus = ^{apb.PADDR[1:0], apb.PWDATA};

    always_comb begin
        rdata = '0;
        rerr  = 1'b0;
        case (off)
            OFF_BTN_STATE: rdata[NUM_BTN-1:0] = btn_level;
            OFF_EDGE:      rdata[NUM_BTN-1:0] = edge_q;
            OFF_IRQ_EN:    rdata[NUM_BTN-1:0] = irq_en_q;
            OFF_LED:       rdata[NUM_LED-1:0] = led_q;
            default:       rerr = 1'b1;
        endcase
    end

    // Writes commit on the ACK edge, and only while the initiator still holds the access.
    assign wr_en = (state_q == ST_ACK) & apb.PSEL & apb.PENABLE & apb.PWRITE;

    always_comb begin
        edge_d   = edge_q;
        irq_en_d = irq_en_q;
        led_d    = led_q;
        if (wr_en && off == OFF_EDGE) begin
            edge_d = edge_q & ~apb.PWDATA[NUM_BTN-1:0];
        end
        if (wr_en && off == OFF_IRQ_EN) begin
            irq_en_d = apb.PWDATA[NUM_BTN-1:0];
        end
        if (wr_en && off == OFF_LED) begin
            led_d = apb.PWDATA[NUM_LED-1:0];
        end
        // A same-cycle rise beats the W1C clear.
        edge_d = edge_d | btn_rise;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            edge_q    <= '0;
            irq_en_q  <= '0;
            led_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            edge_q   <= edge_d;
            irq_en_q <= irq_en_d;
            led_q    <= led_d;
            irq_q    <= |(edge_d & irq_en_d);
            case (state_q)
                ST_IDLE: begin
                    if (apb.PSEL && apb.PENABLE) begin
                        state_q   <= ST_ACK;
                        pready_q  <= 1'b1;
                        pslverr_q <= rerr;
                        prdata_q  <= apb.PWRITE ? 32'h0 : rdata;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                end
            endcase
        end
    end

    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign apb.PRDATA  = prdata_q;
    assign LED_OUT     = led_q;
    assign IRQ         = irq_q;

endmodule

// File: tb/tb_apb_btn_led_target.sv
// Self-checking bench for apb_btn_led_target with a short debounce window.
// Expected responses are queued when a transfer is launched and checked when PREADY rises.
module tb_apb_btn_led_target;

    localparam int unsigned NB = 4;
    localparam int unsigned NL = 4;
    localparam int unsigned DB = 8;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic [NB-1:0] BTN_IN = '0;
    logic [NL-1:0] LED_OUT;
    logic          IRQ;

    apb_btn_led_target_if apb ();

    apb_btn_led_target #(
        .NUM_BTN         (NB),
        .NUM_LED         (NL),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .apb     (apb),
        .BTN_IN  (BTN_IN),
        .LED_OUT (LED_OUT),
        .IRQ     (IRQ)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // Called just after a clock edge; returns just after the commit edge.
    task automatic apb_xfer(input string tag, input logic wr, input logic [4:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata,
                            input logic exp_err);
        logic [32:0] e;
        int waited;
        exp_q.push_back({exp_err, exp_rdata});
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = addr;
        apb.PWDATA  = wdata;
        tick();
        apb.PENABLE = 1'b1;
        check_eq({tag, ":wait"}, 32'(apb.PREADY), 32'd0);
        tick();
        waited = 0;
        while (!apb.PREADY && waited < 4) begin
            tick();
            waited++;
        end
        check_eq({tag, ":lat"}, 32'(waited), 32'd0);
        e = exp_q.pop_front();
        check_eq({tag, ":rdata"}, apb.PRDATA, e[31:0]);
        check_eq({tag, ":err"}, 32'(apb.PSLVERR), 32'(e[32]));
        tick();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        check_eq({tag, ":idle"}, {30'd0, apb.PREADY, apb.PSLVERR} | apb.PRDATA, 32'd0);
    endtask

    initial begin
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;

        // Reset
        tick(3);
        check_eq("rst_pready", 32'(apb.PREADY), 32'd0);
        check_eq("rst_led", 32'(LED_OUT), 32'd0);
        check_eq("rst_irq", 32'(IRQ), 32'd0);
        PRESET = 1'b0;
        tick();
        apb_xfer("rd_btn0", 1'b0, 5'h00, 32'h0, 32'h0, 1'b0);

        // LED register
        apb_xfer("wr_led", 1'b1, 5'h0C, 32'hFFFF_FFF5, 32'h0, 1'b0);
        check_eq("led_out", 32'(LED_OUT), 32'h5);
        apb_xfer("rd_led", 1'b0, 5'h0C, 32'h0, 32'h5, 1'b0);

        // Short glitch is rejected
        BTN_IN[1] = 1'b1;
        tick(5);
        BTN_IN[1] = 1'b0;
        tick(12);
        apb_xfer("glitch_btn", 1'b0, 5'h00, 32'h0, 32'h0, 1'b0);
        apb_xfer("glitch_edge", 1'b0, 5'h04, 32'h0, 32'h0, 1'b0);

        // Stable press: level must still be 0 nine cycles in, then 1
        BTN_IN[1] = 1'b1;
        tick(8);
        apb_xfer("deb_early", 1'b0, 5'h00, 32'h0, 32'h0, 1'b0);
        apb_xfer("deb_btn", 1'b0, 5'h00, 32'h0, 32'h2, 1'b0);
        apb_xfer("deb_edge", 1'b0, 5'h04, 32'h0, 32'h2, 1'b0);
        check_eq("irq_masked", 32'(IRQ), 32'd0);

        // Interrupt enable and W1C clear
        apb_xfer("wr_irqen", 1'b1, 5'h08, 32'h2, 32'h0, 1'b0);
        check_eq("irq_set", 32'(IRQ), 32'd1);
        apb_xfer("rd_irqen", 1'b0, 5'h08, 32'h0, 32'h2, 1'b0);
        apb_xfer("w1c", 1'b1, 5'h04, 32'h2, 32'h0, 1'b0);
        check_eq("irq_clr", 32'(IRQ), 32'd0);
        apb_xfer("rd_edge_clr", 1'b0, 5'h04, 32'h0, 32'h0, 1'b0);

        // Release is not captured; then a rise lands on the W1C commit edge
        BTN_IN[1] = 1'b0;
        tick(15);
        apb_xfer("rel_btn", 1'b0, 5'h00, 32'h0, 32'h0, 1'b0);
        apb_xfer("rel_edge", 1'b0, 5'h04, 32'h0, 32'h0, 1'b0);
        check_eq("rel_irq", 32'(IRQ), 32'd0);
        BTN_IN[1] = 1'b1;
        tick(7);
        apb_xfer("w1c_race", 1'b1, 5'h04, 32'h2, 32'h0, 1'b0);
        check_eq("race_irq", 32'(IRQ), 32'd1);
        apb_xfer("race_edge", 1'b0, 5'h04, 32'h0, 32'h2, 1'b0);

        // Error responses and ignored writes
        apb_xfer("rd_unmap", 1'b0, 5'h14, 32'h0, 32'h0, 1'b1);
        apb_xfer("wr_unmap", 1'b1, 5'h1C, 32'hFFFF_FFFF, 32'h0, 1'b1);
        apb_xfer("wr_ro", 1'b1, 5'h00, 32'hF, 32'h0, 1'b0);
        apb_xfer("keep_btn", 1'b0, 5'h00, 32'h0, 32'h2, 1'b0);
        apb_xfer("keep_edge", 1'b0, 5'h04, 32'h0, 32'h2, 1'b0);
        apb_xfer("keep_irqen", 1'b0, 5'h08, 32'h0, 32'h2, 1'b0);
        apb_xfer("keep_led", 1'b0, 5'h0D, 32'h0, 32'h5, 1'b0);

        // Reset during ACK aborts the write
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        check_eq("rst2_led", 32'(LED_OUT), 32'd0);
        check_eq("rst2_irq", 32'(IRQ), 32'd0);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = 5'h0C;
        apb.PWDATA  = 32'hF;
        tick();
        apb.PENABLE = 1'b1;
        tick();
        check_eq("abort_ack", 32'(apb.PREADY), 32'd1);
        PRESET = 1'b1;
        tick();
        check_eq("abort_pready", 32'(apb.PREADY), 32'd0);
        check_eq("abort_led", 32'(LED_OUT), 32'd0);
        PRESET      = 1'b0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        tick();
        check_eq("abort_led2", 32'(LED_OUT), 32'd0);
        apb_xfer("post_wr", 1'b1, 5'h0C, 32'hA, 32'h0, 1'b0);
        apb_xfer("post_rd", 1'b0, 5'h0C, 32'h0, 32'hA, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
